// File: rtl/darkdbg_pkg.sv
// rtl/darkdbg_pkg.sv - shared types, constants and helpers for darkdbg_uart (DARKDBG_TIMESTAMP_EN widens the snapshot)
package darkdbg_pkg;

`ifdef DARKDBG_TIMESTAMP_EN
    localparam int NWORDS = 5;
`else
    localparam int NWORDS = 4;
`endif

    // Each word is 8 hex chars plus a separator; the last separator is CR, then LF.
    localparam int LINE_LEN = NWORDS * 9 + 1;

    typedef logic [NWORDS-1:0][31:0] snap_t;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_NEXT} state_t;

endpackage

// File: rtl/darkdbg_uart_tx.sv
// rtl/darkdbg_uart_tx.sv - 8N1 byte transmitter, each bit held for DIV clocks
module darkdbg_uart_tx #(
    parameter int DIV = 868
) (
    input  logic       XCLK,
    input  logic       XRES,
    input  logic [7:0] DATA,
    input  logic       VALID,
    output logic       READY,
    output logic       TXD
);
    localparam int CW = $clog2(DIV);

    logic          active;
    logic [8:0]    shift;
    logic [3:0]    nbits;
    logic [CW-1:0] cnt;

    assign READY = !active;

    // shift holds the data bits followed by the stop bit; start bit is driven on accept
    always_ff @(posedge XCLK) begin
        if (XRES) begin
            active <= 1'b0;
            TXD    <= 1'b1;
            shift  <= '1;
            nbits  <= '0;
            cnt    <= '0;
        end else if (!active) begin
            if (VALID) begin
                active <= 1'b1;
                TXD    <= 1'b0;
                shift  <= {1'b1, DATA};
                nbits  <= '0;
                cnt    <= '0;
            end
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
            if (nbits == 4'd9) begin
                active <= 1'b0;
            end else begin
                TXD   <= shift[0];
                shift <= {1'b1, shift[8:1]};
                nbits <= nbits + 4'd1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/darkdbg_uart.sv
// rtl/darkdbg_uart.sv - DEBUG bus change detector, snapshot FIFO and ASCII hex line UART (DARKDBG_TIMESTAMP_EN adds a cycle stamp field)
module darkdbg_uart
    import darkdbg_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 4
) (
    input  logic             XCLK,
    input  logic             XRES,
    input  logic [3:0][31:0] DEBUG,
    output logic             UART_TXD,
    output logic             BUSY,
    output logic [7:0]       DROPS
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(DEPTH);

    logic [3:0][31:0] cur, prv;
    snap_t            entry;
    snap_t            mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, change, push, pop, drop;

    state_t     state;
    snap_t      line;
    logic [5:0] idx;
    logic [3:0] pos;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            cur <= '0;
            prv <= '0;
        end else begin
            cur <= DEBUG;
            prv <= cur;
        end
    end

`ifdef DARKDBG_TIMESTAMP_EN
    logic [31:0] stamp;
    always_ff @(posedge XCLK) begin
        if (XRES) stamp <= '0;
        else      stamp <= stamp + 32'd1;
    end
    assign entry = {stamp, cur};
`else
    assign entry = cur;
`endif

    // The extra pointer bit separates full from empty when the indices match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign change = (cur != prv);
    assign pop    = (state == ST_LOAD);
    assign push   = change && (!full || pop);
    assign drop   = change && full && !pop;

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            DROPS  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop && DROPS != 8'hFF) DROPS <= DROPS + 8'd1;
        end
    end

    always_ff @(posedge XCLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= entry;
    end

    // pos tracks the column within a 9-char field; hex columns consume the top nibble of line.
    always_comb begin
        if (idx == 6'(LINE_LEN - 2))      tx_data = CH_CR;
        else if (idx == 6'(LINE_LEN - 1)) tx_data = CH_LF;
        else if (pos == 4'd8)             tx_data = CH_SPACE;
        else                              tx_data = hex_char(line[NWORDS-1][31:28]);
    end

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            state    <= ST_IDLE;
            line     <= '0;
            idx      <= '0;
            pos      <= '0;
            tx_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (!empty) state <= ST_LOAD;
                ST_LOAD: begin
                    line     <= mem[rd_ptr[AW-1:0]];
                    idx      <= '0;
                    pos      <= '0;
                    tx_valid <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    state    <= ST_NEXT;
                end
                ST_NEXT: begin
                    idx <= idx + 6'd1;
                    pos <= (pos == 4'd8) ? 4'd0 : pos + 4'd1;
                    if (pos != 4'd8) line <= line << 4;
                    if (idx != 6'(LINE_LEN - 1)) begin
                        tx_valid <= 1'b1;
                        state    <= ST_SEND;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign BUSY = !empty || (state != ST_IDLE) || !tx_ready;

    darkdbg_uart_tx #(.DIV(DIV)) u_tx (
        .XCLK  (XCLK),
        .XRES  (XRES),
        .DATA  (tx_data),
        .VALID (tx_valid),
        .READY (tx_ready),
        .TXD   (UART_TXD)
    );
endmodule
